// File: rtl/oric_audio_pkg.sv
// Shared constants and saturation helper for the Oric PSG audio path.
package oric_audio_pkg;

  localparam logic [1:0] MODE_MONO = 2'd0;
  localparam logic [1:0] MODE_ABC  = 2'd1;
  localparam logic [1:0] MODE_ACB  = 2'd2;

  localparam logic [9:0] TAPE_MON_LEVEL = 10'd64;

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)
      return 16'sh7fff;
    else if (v < -18'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

endpackage

// File: rtl/dc_block_lpf.sv
// One audio channel: DC blocker, then one-pole low-pass and saturation.
// Stage 3 on en_hpf, stage 4 (registered output) on en_lpf; idle cycles leave the state untouched.
module dc_block_lpf
  import oric_audio_pkg::*;
#(
  parameter int HPF_SHIFT = 10,
  parameter int LPF_SHIFT = 2
) (
  input  logic               clk_48,
  input  logic               reset,
  input  logic               en_hpf,
  input  logic               en_lpf,
  input  logic signed [16:0] x,
  input  logic               mute,
  output logic signed [15:0] audio
);

  localparam int DW = 17 + HPF_SHIFT;

  logic signed [DW-1:0] d_acc;
  logic signed [17:0]   y_q;
  logic signed [17:0]   p_acc;
  logic signed [17:0]   y_next;
  logic signed [17:0]   p_diff;
  logic signed [17:0]   p_next;

  // d_acc >>> HPF_SHIFT is the running DC estimate; it always fits in 17 bits.
  always_comb begin
    y_next = 18'(x) - 18'(d_acc >>> HPF_SHIFT);
    p_diff = y_q - p_acc;
    p_next = p_acc + (p_diff >>> LPF_SHIFT);
  end

  always_ff @(posedge clk_48) begin
    if (reset) begin
      d_acc <= '0;
      y_q   <= '0;
      p_acc <= '0;
      audio <= '0;
    end else begin
      if (en_hpf) begin
        y_q   <= y_next;
        d_acc <= d_acc + DW'(y_next);
      end
      if (en_lpf) begin
        p_acc <= p_next;
        audio <= mute ? 16'sd0 : sat16(p_next);
      end
    end
  end

endmodule

// File: rtl/psg_audio_mixer.sv
// Resamples the three PSG levels plus tape monitor to one sample per CLK_DIV clocks and mixes to stereo.
// Outputs register 3 cycles after the divider strobe and hold between sample_valid pulses.
module psg_audio_mixer
  import oric_audio_pkg::*;
#(
  parameter int CLK_DIV   = 1000,
  parameter int HPF_SHIFT = 10,
  parameter int LPF_SHIFT = 2
) (
  input  logic               clk_48,
  input  logic               reset,
  input  logic [7:0]         psg_a,
  input  logic [7:0]         psg_b,
  input  logic [7:0]         psg_c,
  input  logic               tape_out,
  input  logic               tape_mon_en,
  input  logic [1:0]         stereo_mode,
  input  logic               mute,
  output logic signed [15:0] AUDIO_L,
  output logic signed [15:0] AUDIO_R,
  output logic               sample_valid
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] div_cnt;
  logic          stb;
  logic [7:0]    a_h, b_h, c_h;
  logic          tape_h, mon_h, mute_h;
  logic [1:0]    mode_h;
  logic          vld_s2, vld_s3;
  logic [9:0]    a10, b10, c10, tape_add, mix_l, mix_r;

  assign stb = (div_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk_48) begin
    if (reset) begin
      div_cnt      <= '0;
      a_h          <= '0;
      b_h          <= '0;
      c_h          <= '0;
      tape_h       <= 1'b0;
      mon_h        <= 1'b0;
      mute_h       <= 1'b0;
      mode_h       <= MODE_MONO;
      vld_s2       <= 1'b0;
      vld_s3       <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      div_cnt <= stb ? '0 : div_cnt + CW'(1);
      if (stb) begin
        a_h    <= psg_a;
        b_h    <= psg_b;
        c_h    <= psg_c;
        tape_h <= tape_out;
        mon_h  <= tape_mon_en;
        mute_h <= mute;
        mode_h <= stereo_mode;
      end
      vld_s2       <= stb;
      vld_s3       <= vld_s2;
      sample_valid <= vld_s3;
    end
  end

  // Worst case 2*255 + 255 + 64 = 829, so 10 bits never overflow.
  always_comb begin
    a10      = {2'b00, a_h};
    b10      = {2'b00, b_h};
    c10      = {2'b00, c_h};
    tape_add = (mon_h && tape_h) ? TAPE_MON_LEVEL : 10'd0;
    case (mode_h)
      MODE_ABC: begin
        mix_l = (a10 << 1) + b10 + tape_add;
        mix_r = (c10 << 1) + b10 + tape_add;
      end
      MODE_ACB: begin
        mix_l = (a10 << 1) + c10 + tape_add;
        mix_r = (b10 << 1) + c10 + tape_add;
      end
      default: begin
        mix_l = a10 + b10 + c10 + tape_add;
        mix_r = mix_l;
      end
    endcase
  end

  dc_block_lpf #(.HPF_SHIFT(HPF_SHIFT), .LPF_SHIFT(LPF_SHIFT)) u_left (
    .clk_48 (clk_48),
    .reset  (reset),
    .en_hpf (vld_s2),
    .en_lpf (vld_s3),
    .x      ($signed({2'b00, mix_l, 5'b00000})),
    .mute   (mute_h),
    .audio  (AUDIO_L)
  );

  dc_block_lpf #(.HPF_SHIFT(HPF_SHIFT), .LPF_SHIFT(LPF_SHIFT)) u_right (
    .clk_48 (clk_48),
    .reset  (reset),
    .en_hpf (vld_s2),
    .en_lpf (vld_s3),
    .x      ($signed({2'b00, mix_r, 5'b00000})),
    .mute   (mute_h),
    .audio  (AUDIO_R)
  );

endmodule

// File: tb/tb_psg_audio_mixer.sv
// Bench: default-rate instance for reset/latency, two fast-rate instances (LPF bypassed / LPF 2) checked against an arithmetic model.
module tb_psg_audio_mixer;

  localparam int DIV_FAST = 8;

  logic               clk_48 = 1'b0;
  logic               reset;
  logic [7:0]         psg_a, psg_b, psg_c;
  logic               tape_out, tape_mon_en, mute;
  logic [1:0]         stereo_mode;
  logic signed [15:0] l0, r0, l1, r1, l2, r2;
  logic               v0, v1, v2;

  int     checks = 0;
  int     errors = 0;
  longint md [2][2];
  longint mp [2][2];
  longint exp_l [2];
  longint exp_r [2];
  int     ref1 [12];
  int     ref2 [12];
  int     first_l, first_r, prev_l, n;
  logic [7:0] save_a;
  logic [1:0] save_mode;

  always #5 clk_48 = ~clk_48;

  psg_audio_mixer dut0 (
    .clk_48(clk_48), .reset(reset), .psg_a(psg_a), .psg_b(psg_b), .psg_c(psg_c),
    .tape_out(tape_out), .tape_mon_en(tape_mon_en), .stereo_mode(stereo_mode), .mute(mute),
    .AUDIO_L(l0), .AUDIO_R(r0), .sample_valid(v0)
  );

  psg_audio_mixer #(.CLK_DIV(DIV_FAST), .HPF_SHIFT(10), .LPF_SHIFT(0)) dut1 (
    .clk_48(clk_48), .reset(reset), .psg_a(psg_a), .psg_b(psg_b), .psg_c(psg_c),
    .tape_out(tape_out), .tape_mon_en(tape_mon_en), .stereo_mode(stereo_mode), .mute(mute),
    .AUDIO_L(l1), .AUDIO_R(r1), .sample_valid(v1)
  );

  psg_audio_mixer #(.CLK_DIV(DIV_FAST), .HPF_SHIFT(10), .LPF_SHIFT(2)) dut2 (
    .clk_48(clk_48), .reset(reset), .psg_a(psg_a), .psg_b(psg_b), .psg_c(psg_c),
    .tape_out(tape_out), .tape_mon_en(tape_mon_en), .stereo_mode(stereo_mode), .mute(mute),
    .AUDIO_L(l2), .AUDIO_R(r2), .sample_valid(v2)
  );

  task automatic tick;
    @(posedge clk_48);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset;
    for (int k = 0; k < 2; k++)
      for (int ch = 0; ch < 2; ch++) begin
        md[k][ch] = 0;
        mp[k][ch] = 0;
      end
  endtask

  // One output sample from the current (stable) inputs; instance 0 has LPF bypassed, instance 1 alpha=1/4.
  task automatic model_step;
    int ml, mr;
    longint x, y, s;
    case (stereo_mode)
      2'd1: begin ml = 2*int'(psg_a) + int'(psg_b); mr = 2*int'(psg_c) + int'(psg_b); end
      2'd2: begin ml = 2*int'(psg_a) + int'(psg_c); mr = 2*int'(psg_b) + int'(psg_c); end
      default: begin ml = int'(psg_a) + int'(psg_b) + int'(psg_c); mr = ml; end
    endcase
    if (tape_mon_en && tape_out) begin
      ml += 64;
      mr += 64;
    end
    for (int k = 0; k < 2; k++)
      for (int ch = 0; ch < 2; ch++) begin
        x = 32 * longint'((ch == 0) ? ml : mr);
        y = x - (md[k][ch] >>> 10);
        md[k][ch] += y;
        mp[k][ch] += (y - mp[k][ch]) >>> ((k == 0) ? 0 : 2);
        s = mp[k][ch];
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (mute) s = 0;
        if (ch == 0) exp_l[k] = s; else exp_r[k] = s;
      end
  endtask

  task automatic check_outputs(input string tag);
    model_step;
    check({tag, "_l_lpf0"}, l1, exp_l[0]);
    check({tag, "_r_lpf0"}, r1, exp_r[0]);
    check({tag, "_l_lpf2"}, l2, exp_l[1]);
    check({tag, "_r_lpf2"}, r2, exp_r[1]);
  endtask

  task automatic sample(input string tag);
    int k = 0;
    do begin tick; k++; end while (v1 !== 1'b1 && k < 4*DIV_FAST);
    check({tag, "_vld"}, v1, 1);
    check({tag, "_vld_pair"}, v2, 1);
    check_outputs(tag);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    model_reset;
  endtask

  initial begin
    reset = 1'b1;
    psg_a = 8'd0; psg_b = 8'd0; psg_c = 8'd0;
    tape_out = 1'b0; tape_mon_en = 1'b0; stereo_mode = 2'd0; mute = 1'b0;
    repeat (5) tick;
    check("t1_rst_l", l0, 0);
    check("t1_rst_r", r0, 0);
    check("t1_rst_vld", v0, 0);
    check("t1_rst_vld_fast", v1, 0);

    // Reset falls inside cycle 1, so a pulse seen after edge n lives in cycle n+1.
    reset = 1'b0;
    n = 0;
    do begin tick; n++; end while (v0 !== 1'b1 && n < 1100);
    check("t1_first_valid_cycle", n + 1, 1003);
    check("t1_idle_l", l0, 0);
    check("t1_idle_r", r0, 0);
    tick;
    check("t1_pulse_width", v0, 0);

    // Mono full-scale step.
    do_reset;
    psg_a = 8'hFF; psg_b = 8'hFF; psg_c = 8'hFF;
    sample("t2_first");
    check("t2_step_l", l1, 24480);
    check("t2_step_r", r1, 24480);
    prev_l = int'(l1);
    tick;
    check("t2_hold", l1, prev_l);
    check("t2_pulse", v1, 0);
    for (int i = 0; i < 150; i++) begin
      sample("t2_decay");
      check("t2_monotonic", (int'(l1) <= prev_l), 1);
      prev_l = int'(l1);
    end

    // ABC, A only.
    do_reset;
    psg_a = 8'h80; psg_b = 8'h00; psg_c = 8'h00; stereo_mode = 2'd1;
    sample("t3");
    check("t3_l_positive", (l1 > 0), 1);
    check("t3_r_zero", r1, 0);
    first_l = int'(l1);
    first_r = int'(r1);

    // ACB with the weight moved to B lands on the right channel only.
    do_reset;
    psg_a = 8'h00; psg_b = 8'h80; psg_c = 8'h00; stereo_mode = 2'd2;
    sample("t4");
    check("t4_mirror_l", l1, first_r);
    check("t4_mirror_r", r1, first_l);

    // Unmuted reference, then the same run muted for the first 4 samples.
    do_reset;
    psg_a = 8'hFF; psg_b = 8'h00; psg_c = 8'h00; stereo_mode = 2'd0;
    for (int i = 0; i < 12; i++) begin
      sample("t5_ref");
      ref1[i] = int'(l1);
      ref2[i] = int'(l2);
    end
    do_reset;
    mute = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) mute = 1'b0;
      sample("t5_run");
      if (i < 4) begin
        check("t5_muted_l", l2, 0);
        check("t5_muted_r", r2, 0);
      end else begin
        check("t5_resume_lpf0", l1, ref1[i]);
        check("t5_resume_lpf2", l2, ref2[i]);
      end
    end

    // Tape monitor only, then reset mid-run.
    do_reset;
    psg_a = 8'd0; psg_b = 8'd0; psg_c = 8'd0; tape_mon_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) tape_out = ~tape_out;
      sample("t6_tape");
    end
    tick;
    tick;
    reset = 1'b1;
    tick;
    check("t6_rst_l", l1, 0);
    check("t6_rst_r", r1, 0);
    check("t6_rst_l2", l2, 0);
    check("t6_rst_vld", v1, 0);
    reset = 1'b0;
    model_reset;
    n = 0;
    do begin tick; n++; end while (v1 !== 1'b1 && n < 64);
    check("t6_restart_edges", n, DIV_FAST + 2);
    check_outputs("t6_restart");
    tape_mon_en = 1'b0;

    // Glitches between strobes must not reach the held samples.
    for (int i = 0; i < 8; i++) begin
      save_a = psg_a;
      save_mode = stereo_mode;
      psg_a = ~psg_a;
      stereo_mode = stereo_mode + 2'd1;
      tick;
      tick;
      psg_a = save_a;
      stereo_mode = save_mode;
      sample("glitch");
    end

    // Random traffic.
    do_reset;
    for (int i = 0; i < 300; i++) begin
      psg_a = 8'($urandom_range(0, 255));
      psg_b = 8'($urandom_range(0, 255));
      psg_c = 8'($urandom_range(0, 255));
      stereo_mode = 2'($urandom_range(0, 3));
      tape_out = 1'($urandom_range(0, 1));
      tape_mon_en = 1'($urandom_range(0, 1));
      mute = ($urandom_range(0, 7) == 0);
      sample("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
